// File: rtl/demux_rr_lanes_if.sv
// Handshake/bus bundle for demux_rr_lanes: word input side plus registered lane outputs.
// master drives the word stream; slave is the demux itself.
interface demux_rr_lanes_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 4
);
    localparam int unsigned PtrW = $clog2(LANES);

    logic                   valid_in;
    logic [WIDTH-1:0]       data_in;
    logic                   flush;
    logic [LANES*WIDTH-1:0] data_out;
    logic [LANES-1:0]       valid_out;
    logic                   group_done;
    logic                   partial;
    logic [PtrW-1:0]        ptr;

    modport master (
        output valid_in, data_in, flush,
        input  data_out, valid_out, group_done, partial, ptr
    );

    modport slave (
        input  valid_in, data_in, flush,
        output data_out, valid_out, group_done, partial, ptr
    );
endinterface

// File: rtl/demux_rr_lanes.sv
// Round-robin word-to-lane demux: gathers LANES words into slots and emits them as one group,
// with flush and idle-timeout emission of partial groups.
module demux_rr_lanes #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LANES   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input logic             clk_f,
    input logic             reset,
    demux_rr_lanes_if.slave bus
);
    localparam int unsigned PtrW  = $clog2(LANES);
    localparam int unsigned IdleW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [PtrW-1:0] LastLane = PtrW'(LANES - 1);

    logic [LANES-1:0][WIDTH-1:0] slot_q, slot_d, fill_slot;
    logic [LANES-1:0]            mask_q, mask_d, fill_mask;
    logic [PtrW-1:0]             ptr_q, ptr_d;
    logic [IdleW-1:0]            idle_q, idle_d;
    logic [LANES-1:0][WIDTH-1:0] data_out_q, data_out_d;
    logic [LANES-1:0]            valid_out_q, valid_out_d;
    logic                        group_done_q, group_done_d;
    logic                        partial_q, partial_d;
    logic                        timeout_hit;

    always_comb begin
        slot_d       = slot_q;
        mask_d       = mask_q;
        ptr_d        = ptr_q;
        idle_d       = idle_q;
        data_out_d   = data_out_q;
        valid_out_d  = '0;
        group_done_d = 1'b0;
        partial_d    = 1'b0;

        // Current word is folded in first so flush/timeout emissions include it.
        fill_slot = slot_q;
        fill_mask = mask_q;
        if (bus.valid_in) begin
            fill_slot[ptr_q] = bus.data_in;
            fill_mask[ptr_q] = 1'b1;
        end

        timeout_hit = (TIMEOUT != 0) && (idle_q == IdleW'(TIMEOUT));

        if (bus.valid_in && (ptr_q == LastLane)) begin
            data_out_d   = fill_slot;
            valid_out_d  = '1;
            group_done_d = 1'b1;
            slot_d       = '0;
            mask_d       = '0;
            ptr_d        = '0;
            idle_d       = '0;
        end else if ((bus.flush || timeout_hit) && (fill_mask != '0)) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                data_out_d[i] = fill_mask[i] ? fill_slot[i] : '0;
            end
            valid_out_d = fill_mask;
            partial_d   = 1'b1;
            slot_d      = '0;
            mask_d      = '0;
            ptr_d       = '0;
            idle_d      = '0;
        end else begin
            slot_d = fill_slot;
            mask_d = fill_mask;
            if (bus.valid_in) begin
                ptr_d  = ptr_q + 1'b1;
                idle_d = '0;
            end else if ((mask_q != '0) && (idle_q != '1)) begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            slot_q       <= '0;
            mask_q       <= '0;
            ptr_q        <= '0;
            idle_q       <= '0;
            data_out_q   <= '0;
            valid_out_q  <= '0;
            group_done_q <= 1'b0;
            partial_q    <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            mask_q       <= mask_d;
            ptr_q        <= ptr_d;
            idle_q       <= idle_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            group_done_q <= group_done_d;
            partial_q    <= partial_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.valid_out  = valid_out_q;
    assign bus.group_done = group_done_q;
    assign bus.partial    = partial_q;
    assign bus.ptr        = ptr_q;
endmodule

// File: tb/tb_demux_rr_lanes.sv
// Directed bench for demux_rr_lanes (WIDTH=8, LANES=4, TIMEOUT=4): per-cycle vector table
// plus hand sequences for timeout and mid-group reset.
module tb_demux_rr_lanes;
    logic clk_f;
    logic reset;
    int   checks;
    int   errors;

    demux_rr_lanes_if #(.WIDTH(8), .LANES(4)) bus ();

    demux_rr_lanes #(.WIDTH(8), .LANES(4), .TIMEOUT(4)) dut (
        .clk_f (clk_f),
        .reset (reset),
        .bus   (bus)
    );

    initial clk_f = 1'b0;
    always #5 clk_f = ~clk_f;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        f;
        logic [3:0]  vo;
        logic [31:0] dout;
        logic        gd;
        logic        p;
        logic [1:0]  ptr;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(logic v, logic [7:0] d, logic f, logic [3:0] vo,
                                logic [31:0] dout, logic gd, logic p, logic [1:0] ptr);
        vec_t r;
        r.v = v; r.d = d; r.f = f; r.vo = vo; r.dout = dout; r.gd = gd; r.p = p; r.ptr = ptr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] vo, input logic [31:0] dout,
                              input logic gd, input logic p, input logic [1:0] ptr);
        chk({tag, ".valid_out"}, 32'(bus.valid_out), 32'(vo));
        chk({tag, ".data_out"}, bus.data_out, dout);
        chk({tag, ".group_done"}, 32'(bus.group_done), 32'(gd));
        chk({tag, ".partial"}, 32'(bus.partial), 32'(p));
        chk({tag, ".ptr"}, 32'(bus.ptr), 32'(ptr));
    endtask

    // Drive inputs on the falling edge, sample 1ns after the next rising edge.
    task automatic step(input logic v, input logic [7:0] d, input logic f);
        @(negedge clk_f);
        bus.valid_in = v;
        bus.data_in  = d;
        bus.flush    = f;
        @(posedge clk_f);
        #1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.flush    = 1'b0;
        reset        = 1'b1;

        vecs[0]  = mk(1, 8'h11, 0, 4'b0000, 32'h0000_0000, 0, 0, 2'd1);
        vecs[1]  = mk(1, 8'h22, 0, 4'b0000, 32'h0000_0000, 0, 0, 2'd2);
        vecs[2]  = mk(1, 8'h33, 0, 4'b0000, 32'h0000_0000, 0, 0, 2'd3);
        vecs[3]  = mk(1, 8'h44, 0, 4'b1111, 32'h4433_2211, 1, 0, 2'd0);
        vecs[4]  = mk(0, 8'h00, 0, 4'b0000, 32'h4433_2211, 0, 0, 2'd0);
        vecs[5]  = mk(1, 8'h01, 0, 4'b0000, 32'h4433_2211, 0, 0, 2'd1);
        vecs[6]  = mk(1, 8'h02, 0, 4'b0000, 32'h4433_2211, 0, 0, 2'd2);
        vecs[7]  = mk(1, 8'h03, 0, 4'b0000, 32'h4433_2211, 0, 0, 2'd3);
        vecs[8]  = mk(1, 8'h04, 0, 4'b1111, 32'h0403_0201, 1, 0, 2'd0);
        vecs[9]  = mk(1, 8'h05, 0, 4'b0000, 32'h0403_0201, 0, 0, 2'd1);
        vecs[10] = mk(1, 8'h06, 0, 4'b0000, 32'h0403_0201, 0, 0, 2'd2);
        vecs[11] = mk(1, 8'h07, 0, 4'b0000, 32'h0403_0201, 0, 0, 2'd3);
        vecs[12] = mk(1, 8'h08, 0, 4'b1111, 32'h0807_0605, 1, 0, 2'd0);
        vecs[13] = mk(1, 8'hA1, 0, 4'b0000, 32'h0807_0605, 0, 0, 2'd1);
        vecs[14] = mk(1, 8'hA2, 0, 4'b0000, 32'h0807_0605, 0, 0, 2'd2);
        vecs[15] = mk(0, 8'h00, 1, 4'b0011, 32'h0000_A2A1, 0, 1, 2'd0);
        vecs[16] = mk(0, 8'h00, 1, 4'b0000, 32'h0000_A2A1, 0, 0, 2'd0);
        vecs[17] = mk(1, 8'hC1, 0, 4'b0000, 32'h0000_A2A1, 0, 0, 2'd1);
        vecs[18] = mk(1, 8'hC2, 0, 4'b0000, 32'h0000_A2A1, 0, 0, 2'd2);
        vecs[19] = mk(1, 8'hC3, 0, 4'b0000, 32'h0000_A2A1, 0, 0, 2'd3);
        vecs[20] = mk(1, 8'hC4, 1, 4'b1111, 32'hC4C3_C2C1, 1, 0, 2'd0);
        vecs[21] = mk(1, 8'hE1, 1, 4'b0001, 32'h0000_00E1, 0, 1, 2'd0);

        repeat (2) @(posedge clk_f);
        #1;
        expect_out("reset", 4'b0000, 32'h0, 0, 0, 2'd0);
        @(negedge clk_f);
        reset = 1'b0;
        step(0, 8'h00, 0);
        expect_out("post_release", 4'b0000, 32'h0, 0, 0, 2'd0);

        for (int i = 0; i < 22; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].f);
            expect_out($sformatf("vec%0d", i), vecs[i].vo, vecs[i].dout, vecs[i].gd,
                       vecs[i].p, vecs[i].ptr);
        end

        // Idle timeout: counter reaches 4 after four idle edges, emission on the fifth.
        step(1, 8'hB1, 0);
        expect_out("to_word", 4'b0000, 32'h0000_00E1, 0, 0, 2'd1);
        for (int i = 0; i < 4; i++) begin
            step(0, 8'h00, 0);
            expect_out($sformatf("to_idle%0d", i), 4'b0000, 32'h0000_00E1, 0, 0, 2'd1);
        end
        step(0, 8'h00, 0);
        expect_out("to_emit", 4'b0001, 32'h0000_00B1, 0, 1, 2'd0);
        step(0, 8'h00, 0);
        expect_out("to_after", 4'b0000, 32'h0000_00B1, 0, 0, 2'd0);

        // A new word restarts the idle count.
        step(1, 8'hB2, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 0);
        step(1, 8'hB3, 0);
        expect_out("rst_idle_word", 4'b0000, 32'h0000_00B1, 0, 0, 2'd2);
        for (int i = 0; i < 4; i++) begin
            step(0, 8'h00, 0);
            expect_out($sformatf("rst_idle%0d", i), 4'b0000, 32'h0000_00B1, 0, 0, 2'd2);
        end
        step(0, 8'h00, 0);
        expect_out("rst_idle_emit", 4'b0011, 32'h0000_B3B2, 0, 1, 2'd0);

        // Flush coinciding with timeout yields a single emission.
        step(1, 8'hB4, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0);
        step(0, 8'h00, 1);
        expect_out("both_emit", 4'b0001, 32'h0000_00B4, 0, 1, 2'd0);
        step(0, 8'h00, 1);
        expect_out("both_after", 4'b0000, 32'h0000_00B4, 0, 0, 2'd0);

        // Reset mid-group discards the pair without emitting.
        step(1, 8'h55, 0);
        step(1, 8'h66, 0);
        expect_out("pre_rst", 4'b0000, 32'h0000_00B4, 0, 0, 2'd2);
        @(negedge clk_f);
        bus.valid_in = 1'b0;
        reset        = 1'b1;
        #1;
        expect_out("async_rst", 4'b0000, 32'h0, 0, 0, 2'd0);
        @(negedge clk_f);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(0, 8'h00, 0);
            expect_out($sformatf("rst_quiet%0d", i), 4'b0000, 32'h0, 0, 0, 2'd0);
        end
        step(1, 8'hD1, 0);
        step(1, 8'hD2, 0);
        step(1, 8'hD3, 0);
        expect_out("d_fill", 4'b0000, 32'h0, 0, 0, 2'd3);
        step(1, 8'hD4, 0);
        expect_out("d_full", 4'b1111, 32'hD4D3_D2D1, 1, 0, 2'd0);
        step(0, 8'h00, 0);
        expect_out("d_hold", 4'b0000, 32'hD4D3_D2D1, 0, 0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux_rr_lanes.md
DEMUX_RR_LANES -- requirements
Module: demux_rr_lanes

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, meaning byte/word width of each lane.
REQ-002 The block SHALL provide parameter LANES, default 4, meaning the number of output lanes (legal 2..8).
REQ-003 The block SHALL provide parameter TIMEOUT, default 16, meaning idle cycles before auto-flush of a partial group (0 = disabled).
REQ-004 clk_f  input  1  single clock, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 valid_in  input  1  data_in carries a word this cycle.
REQ-007 data_in  input  WIDTH  input word.
REQ-008 flush  input  1  force emission of a partial group.
REQ-009 data_out  output  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH], registered.
REQ-010 valid_out  output  LANES  per-lane valid, one-cycle pulse per emission.
REQ-011 group_done  output  1  one-cycle pulse on a full-group emission.
REQ-012 partial  output  1  one-cycle pulse on a partial-group emission.
REQ-013 ptr  output  clog2(LANES)  next lane to be filled.

Function
REQ-014 Accepted words SHALL fill internal slots round-robin: slot[ptr] <= data_in, mask[ptr] <= 1, ptr <= ptr+1 on each cycle with valid_in=1.
REQ-015 Cycles with valid_in=0 SHALL leave ptr, slots and mask unchanged (no lane skipping).
REQ-016 When valid_in=1 and ptr=LANES-1, the next cycle SHALL present all LANES words on data_out, valid_out = all ones, group_done=1; ptr and mask SHALL clear to 0 in the same edge (1-cycle latency from last word).
REQ-017 Words accepted in the cycle immediately following a completion SHALL go to lane 0 with no bubble (full throughput, one word per cycle).
REQ-018 flush=1 with mask nonzero SHALL emit next cycle: data_out = filled slots, unfilled lanes = 0, valid_out = mask, partial=1, group_done=0; ptr and mask clear.
REQ-019 flush=1 with valid_in=1 SHALL include the current word before emitting; if that word completes the group the emission SHALL be a full one (group_done=1, partial=0).
REQ-020 flush=1 with mask=0 and valid_in=0 SHALL have no effect.
REQ-021 An idle counter SHALL increment on each cycle with valid_in=0 and mask nonzero, and clear on valid_in=1 or any emission.
REQ-022 When TIMEOUT>0 and the idle counter reaches TIMEOUT, the block SHALL perform an emission identical to REQ-018 on the following cycle.
REQ-023 Simultaneous flush and timeout SHALL produce exactly one emission.
REQ-024 data_out SHALL hold its last emitted value between emissions; valid_out, group_done, partial SHALL be 0 in non-emission cycles.
REQ-025 Idle counter width SHALL be clog2(TIMEOUT+1) and SHALL saturate, never wrap.

Reset
REQ-026 reset=1 SHALL asynchronously clear data_out, valid_out, group_done, partial, ptr, slots, mask and idle counter to 0.
REQ-027 Reset asserted mid-group SHALL discard the partial group with no emission; first word after release goes to lane 0.
REQ-028 No emission SHALL occur in the first edge after reset release unless inputs request one.

Verification (WIDTH=8, LANES=4, TIMEOUT=4)
REQ-029 valid_in=1 for 4 cycles with 0x11,0x22,0x33,0x44 -> next cycle data_out=0x44332211, valid_out=4'b1111, group_done=1.
REQ-030 8 back-to-back words 0x01..0x08 -> two consecutive group_done pulses, data_out 0x04030201 then 0x08070605.
REQ-031 Words 0xA1,0xA2 then flush=1 -> data_out=0x0000A2A1, valid_out=4'b0011, partial=1, ptr=0.
REQ-032 Word 0xB1 then valid_in=0 for 4 cycles -> auto emission 0x000000B1, valid_out=4'b0001, partial=1 on the 5th cycle.
REQ-033 Words 0xC1,0xC2,0xC3 then 0xC4 with flush=1 -> full emission 0xC4C3C2C1, group_done=1, partial=0.
REQ-034 Two words accepted, reset pulsed, then 0xD1..0xD4 -> no emission from the discarded pair, then 0xD4D3D2D1 full group.
